// File: rtl/mem_checker_pkg.sv
// mem_checker shared types: FSM states and preload select encodings.
package mem_checker_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      REPORT,
      DONE
   } state_e;

   localparam logic LD_SHADOW = 1'b0;
   localparam logic LD_GOLDEN = 1'b1;

endpackage

// File: rtl/mem_checker_if.sv
// mem_checker input bus: monitored cache write, PC and image preload.
interface mem_checker_if #(
   parameter int DW     = 32,
   parameter int ADDR_W = 30,
   parameter int AW     = 8
);

   logic              wen;
   logic [ADDR_W-1:0] addr;
   logic [DW-1:0]     data;
   logic [31:0]       pc;
   logic              ld_en;
   logic              ld_sel;
   logic [AW-1:0]     ld_addr;
   logic [DW-1:0]     ld_data;

   modport master (
      output wen, addr, data, pc,
      output ld_en, ld_sel, ld_addr, ld_data
   );

   modport slave (
      input wen, addr, data, pc,
      input ld_en, ld_sel, ld_addr, ld_data
   );

endinterface

// File: rtl/mem_checker_ram.sv
// Shadow and golden image arrays; contents survive reset on purpose.
module mem_checker_ram #(
   parameter int DW    = 32,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          s_we,
   input  logic [AW-1:0] s_waddr,
   input  logic [DW-1:0] s_wdata,
   input  logic          g_we,
   input  logic [AW-1:0] g_waddr,
   input  logic [DW-1:0] g_wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] s_rdata,
   output logic [DW-1:0] g_rdata
);

   logic [DW-1:0] shadow_mem [DEPTH];
   logic [DW-1:0] golden_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (s_we) shadow_mem[s_waddr] <= s_wdata;
      if (g_we) golden_mem[g_waddr] <= g_wdata;
   end

   assign s_rdata = shadow_mem[raddr];
   assign g_rdata = golden_mem[raddr];

endmodule

// File: rtl/mem_checker.sv
// Captures DUT cache writes until pc hits END_PC, then diffs shadow vs golden.
// Optional watchdog enabled by defining MEM_CHECKER_TIMEOUT_EN.
module mem_checker
   import mem_checker_pkg::*;
#(
   parameter int DW          = 32,
   parameter int DEPTH       = 256,
   parameter int ADDR_W      = 30,
   parameter int END_PC      = 400,
   parameter int TIMEOUT_CYC = 10000000,
   localparam int AW         = $clog2(DEPTH),
   localparam int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   mem_checker_if.slave     bus,
   output logic [CNT_W-1:0] error_num,
   output logic             finish,
   output logic             pass,
   output logic             err_valid,
   output logic [AW-1:0]    first_err_addr,
   output logic [31:0]      duration,
   output logic             timeout
);

   state_e             state_q, state_d;
   logic [AW-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]   err_q, err_d;
   logic               err_valid_q, err_valid_d;
   logic [AW-1:0]      first_q, first_d;
   logic [31:0]        dur_q, dur_d;
   logic               in_idle, pc_end, wr_hit, to_hit;
   logic               s_we, g_we, mismatch;
   logic [AW-1:0]      s_waddr;
   logic [DW-1:0]      s_wdata, s_rdata, g_rdata;

   assign in_idle = (state_q == IDLE);
   assign pc_end  = (bus.pc >= 32'(END_PC));
   assign wr_hit  = in_idle && bus.wen && (bus.addr < ADDR_W'(DEPTH));

   // A cache write beats a shadow preload in the same cycle
   assign s_we    = wr_hit || (in_idle && bus.ld_en && bus.ld_sel == LD_SHADOW);
   assign s_waddr = wr_hit ? bus.addr[AW-1:0] : bus.ld_addr;
   assign s_wdata = wr_hit ? bus.data : bus.ld_data;
   assign g_we    = in_idle && bus.ld_en && (bus.ld_sel == LD_GOLDEN);

   mem_checker_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .s_we    (s_we),
      .s_waddr (s_waddr),
      .s_wdata (s_wdata),
      .g_we    (g_we),
      .g_waddr (bus.ld_addr),
      .g_wdata (bus.ld_data),
      .raddr   (idx_q),
      .s_rdata (s_rdata),
      .g_rdata (g_rdata)
   );

   assign mismatch = (s_rdata != g_rdata);

`ifdef MEM_CHECKER_TIMEOUT_EN
   logic timeout_q;
   assign to_hit = in_idle && (dur_q >= 32'(TIMEOUT_CYC));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) timeout_q <= 1'b0;
      else      timeout_q <= timeout_q | to_hit;
   end

   assign timeout = timeout_q;
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = (TIMEOUT_CYC == 0);
   assign to_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      err_d       = err_q;
      err_valid_d = err_valid_q;
      first_d     = first_q;
      dur_d       = dur_q;
      unique case (state_q)
         IDLE: begin
            idx_d = '0;
            if (to_hit)      state_d = REPORT;
            else if (pc_end) state_d = CHECK;
            else             dur_d   = dur_q + 32'd1;
         end
         CHECK: begin
            idx_d = idx_q + 1'b1;
            if (mismatch) begin
               if (err_q != CNT_W'(DEPTH)) err_d = err_q + 1'b1;
               if (!err_valid_q) begin
                  err_valid_d = 1'b1;
                  first_d     = idx_q;
               end
            end
            if (idx_q == AW'(DEPTH - 1)) state_d = REPORT;
         end
         REPORT:  state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         err_q       <= '0;
         err_valid_q <= 1'b0;
         first_q     <= '0;
         dur_q       <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
         err_valid_q <= err_valid_d;
         first_q     <= first_d;
         dur_q       <= dur_d;
      end
   end

   assign finish         = (state_q == REPORT) || (state_q == DONE);
   assign pass           = finish && (err_q == '0) && !timeout;
   assign error_num      = err_q;
   assign err_valid      = err_valid_q;
   assign first_err_addr = first_q;
   assign duration       = dur_q;

endmodule

// File: tb/tb_mem_checker.sv
// Directed self-checking bench for mem_checker (default build and watchdog build).
module tb_mem_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic [8:0] error_num;
   logic       finish, pass, err_valid, timeout;
   logic [7:0] first_err_addr;
   logic [31:0] duration;
   int         n_chk = 0;
   int         n_err = 0;
   int         cyc;

   always #5 clk = ~clk;

   mem_checker_if #(.DW(32), .ADDR_W(30), .AW(8)) bus ();

   mem_checker u_dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .error_num      (error_num),
      .finish         (finish),
      .pass           (pass),
      .err_valid      (err_valid),
      .first_err_addr (first_err_addr),
      .duration       (duration),
      .timeout        (timeout)
   );

`ifdef MEM_CHECKER_TIMEOUT_EN
   logic [8:0]  to_error_num;
   logic        to_finish, to_pass, to_err_valid, to_timeout;
   logic [7:0]  to_first;
   logic [31:0] to_duration;

   mem_checker_if #(.DW(32), .ADDR_W(30), .AW(8)) bus2 ();

   mem_checker #(.TIMEOUT_CYC(20)) u_wd (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus2),
      .error_num      (to_error_num),
      .finish         (to_finish),
      .pass           (to_pass),
      .err_valid      (to_err_valid),
      .first_err_addr (to_first),
      .duration       (to_duration),
      .timeout        (to_timeout)
   );
`endif

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_err"},   32'(error_num), 0);
      check({tag, "_fin"},   32'(finish), 0);
      check({tag, "_pass"},  32'(pass), 0);
      check({tag, "_vld"},   32'(err_valid), 0);
      check({tag, "_first"}, 32'(first_err_addr), 0);
      check({tag, "_dur"},   duration, 0);
      check({tag, "_to"},    32'(timeout), 0);
   endtask

   // Called just after a clock edge; release lands well before the next edge
   task automatic do_reset;
      bus.pc = 0;
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   task automatic load(input logic sel, input int a, input logic [31:0] d);
      bus.ld_en   = 1'b1;
      bus.ld_sel  = sel;
      bus.ld_addr = 8'(a);
      bus.ld_data = d;
      tick();
      bus.ld_en = 1'b0;
   endtask

   task automatic wait_finish(output int n);
      n = 0;
      while (!finish && n < 1000) begin
         tick();
         n++;
      end
      if (!finish) check("finish_wait", 0, 1);
   endtask

   initial begin
      rst         = 1'b0;
      bus.wen     = 1'b0;
      bus.addr    = '0;
      bus.data    = '0;
      bus.pc      = '0;
      bus.ld_en   = 1'b0;
      bus.ld_sel  = 1'b0;
      bus.ld_addr = '0;
      bus.ld_data = '0;
`ifdef MEM_CHECKER_TIMEOUT_EN
      bus2.wen     = 1'b0;
      bus2.addr    = '0;
      bus2.data    = '0;
      bus2.pc      = '0;
      bus2.ld_en   = 1'b0;
      bus2.ld_sel  = 1'b0;
      bus2.ld_addr = '0;
      bus2.ld_data = '0;
`endif
      tick();
      check_zero("rst0");
      do_reset();

`ifdef MEM_CHECKER_TIMEOUT_EN
      repeat (20) tick();
      check("wd_to_pre",  32'(to_timeout), 0);
      check("wd_dur_pre", to_duration, 20);
      tick();
      check("wd_to",   32'(to_timeout), 1);
      check("wd_fin",  32'(to_finish), 1);
      check("wd_pass", 32'(to_pass), 0);
      check("wd_dur",  to_duration, 20);
`else
      check("no_wd_to", 32'(timeout), 0);
`endif

      for (int i = 0; i < 256; i++) begin
         load(1'b1, i, 32'(i));
         load(1'b0, i, 32'(i));
      end

      // Clean image: 50 IDLE cycles, then pc reaches END_PC
      do_reset();
      check_zero("rst1");
      repeat (50) tick();
      check("t1_dur_idle", duration, 50);
      bus.pc = 400;
      tick();
      check("t1_dur", duration, 50);
      check("t1_fin_early", 32'(finish), 0);
      wait_finish(cyc);
      check("t1_latency", 32'(cyc), 256);
      check("t1_pass", 32'(pass), 1);
      check("t1_err", 32'(error_num), 0);
      check("t1_vld", 32'(err_valid), 0);
      repeat (3) tick();
      check("t1_done_fin", 32'(finish), 1);
      check("t1_done_dur", duration, 50);

      // Single corrupt word at 5
      do_reset();
      tick();
      bus.wen  = 1'b1;
      bus.addr = 30'd5;
      bus.data = 32'hdead;
      tick();
      bus.wen = 1'b0;
      bus.pc  = 400;
      tick();
      wait_finish(cyc);
      check("t2_err", 32'(error_num), 1);
      check("t2_first", 32'(first_err_addr), 5);
      check("t2_vld", 32'(err_valid), 1);
      check("t2_pass", 32'(pass), 0);

      // Write on the END_PC cycle is captured and beats a preload; later write dropped
      do_reset();
      load(1'b0, 5, 32'd5);
      bus.ld_en   = 1'b1;
      bus.ld_sel  = 1'b0;
      bus.ld_addr = 8'd7;
      bus.ld_data = 32'd7;
      bus.wen     = 1'b1;
      bus.addr    = 30'd7;
      bus.data    = 32'hbad;
      bus.pc      = 400;
      tick();
      bus.ld_en = 1'b0;
      bus.addr  = 30'd9;
      tick();
      bus.wen = 1'b0;
      wait_finish(cyc);
      check("t3_err", 32'(error_num), 1);
      check("t3_first", 32'(first_err_addr), 7);
      check("t3_vld", 32'(err_valid), 1);

      // Out-of-range write (300 aliases 44 if truncated) is dropped
      do_reset();
      load(1'b0, 7, 32'd7);
      bus.wen  = 1'b1;
      bus.addr = 30'd300;
      bus.data = 32'hbad;
      tick();
      bus.wen = 1'b0;
      bus.pc  = 400;
      tick();
      wait_finish(cyc);
      check("t4_err", 32'(error_num), 0);
      check("t4_pass", 32'(pass), 1);

      // Reset while comparing index 100, then rerun on retained images
      do_reset();
      bus.pc = 400;
      tick();
      check("t5_dur", duration, 0);
      repeat (100) tick();
      check("t5_fin_mid", 32'(finish), 0);
      rst = 1'b0;
      #1;
      check_zero("t5_mid");
      bus.pc = 0;
      rst = 1'b1;
      bus.pc = 400;
      tick();
      wait_finish(cyc);
      check("t5_latency", 32'(cyc), 256);
      check("t5_err", 32'(error_num), 0);
      check("t5_pass", 32'(pass), 1);

      // Every shadow word corrupted
      do_reset();
      for (int i = 0; i < 256; i++) load(1'b0, i, ~32'(i));
      bus.pc = 400;
      tick();
      wait_finish(cyc);
      check("t6_err", 32'(error_num), 256);
      check("t6_first", 32'(first_err_addr), 0);
      check("t6_vld", 32'(err_valid), 1);
      check("t6_pass", 32'(pass), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
